// File: rtl/tdes_pkg.sv
// tdes_pkg: command codes, sequencer states and block type for the 3DES host sequencer.
package tdes_pkg;
  localparam logic [2:0] KEY1 = 3'b010;
  localparam logic [2:0] KEY2 = 3'b011;
  localparam logic [2:0] ENC  = 3'b001;
  localparam logic [2:0] DEC  = 3'b000;
  typedef enum logic [2:0] {IDLE, KEY_CMD, BLK_CMD, WAIT_RES, HOLD_OUT} state_e;
  typedef logic [63:0] block_t;
endpackage

// File: rtl/tdes_out_buf.sv
// tdes_out_buf: one-entry result register with valid/ready handshake.
module tdes_out_buf
  import tdes_pkg::*;
(
  input  logic   clk,
  input  logic   n_rst,
  input  logic   load,
  input  block_t load_data,
  input  logic   out_ready,
  output logic   out_valid,
  output block_t out_data
);
  logic   valid_q, valid_d;
  block_t data_q, data_d;
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = load ? load_data : data_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/tdes_host_sequencer.sv
// tdes_host_sequencer: sole master of the 3DES command port; loads keys, issues blocks, returns results.
// Optional engine-response watchdog with sticky err_timeout when TDES_SEQ_TIMEOUT_EN is defined.
module tdes_host_sequencer
  import tdes_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_valid,
  input  logic             key_sel,
  input  logic [63:0]      key_data,
  output logic             key_ready,
  input  logic             in_valid,
  input  logic             in_decrypt,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  input  logic             out_ready,
  output logic             des_enable,
  output logic [2:0]       des_mode,
  output logic [63:0]      des_data_in,
  input  logic             des_data_ready,
  input  logic [63:0]      des_data_out,
  output logic [1:0]       keys_loaded,
`ifdef TDES_SEQ_TIMEOUT_EN
  output logic             err_timeout,
`endif
  output logic [CNT_W-1:0] blk_count,
  output logic             busy
);
  state_e             state_q, state_d;
  logic               key_sel_q, key_sel_d;
  logic               dec_q, dec_d;
  block_t             data_q, data_d;
  logic [1:0]         keys_q, keys_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_load, tmo_fire;
  block_t             res_data;

  // combinational outputs are forced low while reset is held
  assign key_ready   = n_rst && state_q == IDLE;
  assign in_ready    = key_ready && keys_q == 2'b11 && !out_valid && !key_valid;
  assign des_enable  = state_q == KEY_CMD || state_q == BLK_CMD;
  assign des_mode    = !n_rst ? DEC : state_q == IDLE ? KEY1 :
                       state_q == KEY_CMD ? (key_sel_q ? KEY2 : KEY1) : (dec_q ? DEC : ENC);
  assign des_data_in = data_q;
  assign keys_loaded = keys_q;
  assign blk_count   = cnt_q;
  assign busy        = state_q != IDLE;

  always_comb begin
    state_d   = state_q;
    key_sel_d = key_sel_q;
    dec_d     = dec_q;
    data_d    = data_q;
    keys_d    = keys_q;
    cnt_d     = cnt_q;
    res_load  = 1'b0;
    res_data  = des_data_out;
    case (state_q)
      IDLE:
        if (key_valid) begin
          key_sel_d = key_sel;
          data_d    = key_data;
          state_d   = KEY_CMD;
        end else if (in_valid && in_ready) begin
          dec_d   = in_decrypt;
          data_d  = in_data;
          state_d = BLK_CMD;
        end
      KEY_CMD: begin
        keys_d[key_sel_q] = 1'b1;
        state_d           = IDLE;
      end
      BLK_CMD: state_d = WAIT_RES;
      WAIT_RES:
        if (des_data_ready || tmo_fire) begin
          res_load = 1'b1;
          res_data = des_data_ready ? des_data_out : '0;
          cnt_d    = cnt_q + CNT_W'(des_data_ready);
          state_d  = out_ready ? IDLE : HOLD_OUT;
        end
      HOLD_OUT: state_d = (out_valid && out_ready) ? IDLE : HOLD_OUT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q   <= IDLE;
      key_sel_q <= 1'b0;
      dec_q     <= 1'b0;
      data_q    <= '0;
      keys_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      key_sel_q <= key_sel_d;
      dec_q     <= dec_d;
      data_q    <= data_d;
      keys_q    <= keys_d;
      cnt_q     <= cnt_d;
    end

`ifdef TDES_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  assign tmo_fire = state_q == WAIT_RES && !des_data_ready && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    tmo_d = state_q == WAIT_RES ? tmo_q + TW'(1) : '0;
    err_d = err_q | tmo_fire;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  assign err_timeout = err_q;
`else
  assign tmo_fire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  tdes_out_buf u_out_buf (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (res_load),
    .load_data (res_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );
endmodule

// File: tb/tb_tdes_host_sequencer.sv
// tb_tdes_host_sequencer: scoreboard bench for tdes_host_sequencer with a delayed-response engine model.
module tb_tdes_host_sequencer;
  localparam int CNT_W = 2;
  localparam int TMO   = 8;

  logic clk = 0, n_rst = 0;
  logic key_valid = 0, key_sel = 0, in_valid = 0, in_decrypt = 0, out_ready = 0;
  logic [63:0] key_data = '0, in_data = '0, eng_data = '0, eng_resp = '0;
  logic eng_rdy = 0, stray_rdy = 0, des_data_ready;
  logic key_ready, in_ready, out_valid, des_enable, busy;
  logic [63:0] out_data, des_data_in;
  logic [2:0] des_mode;
  logic [1:0] keys_loaded;
  logic [CNT_W-1:0] blk_count;
  bit eng_mute = 0;
  int eng_delay = 5;
`ifdef TDES_SEQ_TIMEOUT_EN
  logic err_timeout;
`endif

  assign des_data_ready = eng_rdy | stray_rdy;
  always #5 clk = ~clk;

  tdes_host_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .key_valid(key_valid), .key_sel(key_sel), .key_data(key_data), .key_ready(key_ready),
    .in_valid(in_valid), .in_decrypt(in_decrypt), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .des_enable(des_enable), .des_mode(des_mode), .des_data_in(des_data_in),
    .des_data_ready(des_data_ready), .des_data_out(eng_data),
    .keys_loaded(keys_loaded),
`ifdef TDES_SEQ_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .blk_count(blk_count), .busy(busy)
  );

  int tests = 0, fails = 0;
  typedef struct {logic [2:0] m; logic [63:0] d;} cmd_t;
  cmd_t cmd_q[$];
  logic [63:0] exp_q[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // engine model: answers ENC/DEC strobes eng_delay cycles later
  initial forever begin
    @(negedge clk);
    if (des_enable && (des_mode == 3'b000 || des_mode == 3'b001) && !eng_mute) begin
      repeat (eng_delay) @(posedge clk);
      #1 eng_data = eng_resp; eng_rdy = 1;
      @(posedge clk);
      #1 eng_rdy = 0;
    end
  end

  logic prev_en = 0;
  always @(negedge clk) begin
    if (des_enable) begin
      chk("no_back_to_back_enable", 64'(prev_en), 64'd0);
      if (cmd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_cmd: got mode %b data %h, expected no command", des_mode, des_data_in);
      end else begin
        cmd_t c;
        c = cmd_q.pop_front();
        chk("des_mode", 64'(des_mode), 64'(c.m));
        chk("des_data_in", des_data_in, c.d);
      end
    end
    prev_en = des_enable;
  end

  always @(negedge clk)
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h, expected no result", out_data);
      end else chk("out_data", out_data, exp_q.pop_front());
    end

  task automatic send_key(input logic sel, input logic [63:0] k);
    int n = 0;
    cmd_q.push_back('{m: sel ? 3'b011 : 3'b010, d: k});
    @(posedge clk);
    #1 key_sel = sel; key_data = k; key_valid = 1;
    @(negedge clk);
    while (!key_ready && n < 50) begin n++; @(negedge clk); end
    chk("key_accept", 64'(key_ready), 64'd1);
    chk("key_priority_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 key_valid = 0;
  endtask

  task automatic issue_blk(input logic dec, input logic [63:0] d, input logic [63:0] r, input bit expect_out);
    cmd_q.push_back('{m: dec ? 3'b000 : 3'b001, d: d});
    if (expect_out) exp_q.push_back(r);
    eng_resp = r;
    @(posedge clk);
    #1 in_decrypt = dec; in_data = d; in_valid = 1;
  endtask

  task automatic accept_blk();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    chk("blk_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin n++; @(negedge clk); end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic send_blk(input logic dec, input logic [63:0] d, input logic [63:0] r);
    issue_blk(dec, d, r, 1);
    accept_blk();
    wait_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #23;
    chk("rst_key_ready", 64'(key_ready), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_des_enable", 64'(des_enable), 0);
    chk("rst_des_mode", 64'(des_mode), 0);
    chk("rst_des_data_in", des_data_in, 0);
    chk("rst_keys_loaded", 64'(keys_loaded), 0);
    chk("rst_blk_count", 64'(blk_count), 0);
    chk("rst_busy", 64'(busy), 0);
`ifdef TDES_SEQ_TIMEOUT_EN
    chk("rst_err_timeout", 64'(err_timeout), 0);
`endif
    @(posedge clk);
    #1 n_rst = 1; out_ready = 1;
    @(negedge clk);
    chk("idle_key_ready", 64'(key_ready), 1);
    chk("idle_des_mode_key1", 64'(des_mode), 64'(3'b010));

    // key1, then stall a block until key2 arrives
    send_key(0, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("key_cmd_busy", 64'(busy), 1);
    @(negedge clk);
    chk("keys_after_key1", 64'(keys_loaded), 64'd1);
    @(posedge clk);
    #1 in_valid = 1; in_decrypt = 0; in_data = 64'hA5A5A5A55A5A5A5A;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 0);
    end
    chk("stall_not_busy", 64'(busy), 0);
    send_key(1, 64'hFEDCBA9876543210);
    send_blk(0, 64'hA5A5A5A55A5A5A5A, 64'hDEADBEEFCAFEF00D);
    chk("keys_both", 64'(keys_loaded), 64'd3);
    @(negedge clk);
    chk("out_valid_one_cycle", 64'(out_valid), 0);
    chk("blk_count_1", 64'(blk_count), 1);

    // backpressure: result held, next block stalled
    @(posedge clk);
    #1 out_ready = 0;
    send_blk(0, 64'h0F0F0F0F0F0F0F0F, 64'h123456789ABCDEF0);
    issue_blk(1, 64'hC3C3C3C33C3C3C3C, 64'h0BADF00D13579BDF, 1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_out_data_stable", out_data, 64'h123456789ABCDEF0);
      chk("bp_in_ready", 64'(in_ready), 0);
    end
    chk("bp_busy_hold", 64'(busy), 1);
    @(posedge clk);
    #1 out_ready = 1;
    accept_blk();
    wait_out();
    chk("blk_count_3", 64'(blk_count), 3);

    // fourth block wraps the 2-bit counter
    send_blk(0, 64'h0000000000000001, 64'h8000000000000000);
    chk("blk_count_wrap", 64'(blk_count), 0);

    // stray engine strobe while idle is ignored
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 stray_rdy = 1;
    @(posedge clk);
    #1 stray_rdy = 0;
    @(negedge clk);
    chk("stray_out_valid", 64'(out_valid), 0);
    chk("stray_blk_count", 64'(blk_count), 0);
    chk("stray_busy", 64'(busy), 0);

    // key reload while idle, then a block using it
    send_key(0, 64'h1122334455667788);
    repeat (2) @(negedge clk);
    chk("keys_after_reload", 64'(keys_loaded), 64'd3);
    send_blk(1, 64'h2222222222222222, 64'h3333333333333333);
    chk("blk_count_after_reload", 64'(blk_count), 1);

    // reset while waiting for the engine
    eng_mute = 1;
    issue_blk(0, 64'h7777777777777777, 64'h0, 0);
    accept_blk();
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(busy), 1);
    chk("wait_no_enable", 64'(des_enable), 0);
    chk("wait_data_in_held", des_data_in, 64'h7777777777777777);
    #2 n_rst = 0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_keys", 64'(keys_loaded), 0);
    chk("mid_rst_blk_count", 64'(blk_count), 0);
    chk("mid_rst_key_ready", 64'(key_ready), 0);
    chk("mid_rst_des_mode", 64'(des_mode), 0);
    chk("mid_rst_des_data_in", des_data_in, 0);
    @(posedge clk);
    #1 n_rst = 1; eng_mute = 0;

`ifdef TDES_SEQ_TIMEOUT_EN
    send_key(0, 64'h0123456789ABCDEF);
    send_key(1, 64'hFEDCBA9876543210);
    send_blk(0, 64'h4444444444444444, 64'h5555555555555555);
    chk("tmo_pre_count", 64'(blk_count), 1);
    eng_mute = 1;
    issue_blk(0, 64'h6666666666666666, 64'h0, 1);
    accept_blk();
    repeat (9) @(negedge clk);
    chk("tmo_not_early", 64'(out_valid), 0);
    @(negedge clk);
    chk("tmo_out_valid", 64'(out_valid), 1);
    chk("tmo_err", 64'(err_timeout), 1);
    chk("tmo_blk_count", 64'(blk_count), 1);
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", 64'(err_timeout), 1);
    eng_mute = 0;
`endif

    repeat (5) @(negedge clk);
    chk("cmd_q_drained", 64'(cmd_q.size()), 0);
    chk("exp_q_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdes_host_sequencer.md
Name: tdes_host_sequencer

Overview:
- Host-side initiator for the 3DES top-level command interface.
- Accepts key-load requests and 64-bit blocks over valid/ready handshakes.
- Drives the engine's mode/enable/data_in command bus, waits for the engine's data_ready, and returns results over a valid/ready output with one-entry skid buffering.
- Sits between a bus/DMA front end and the 3DES top, and is the only master of that top's command port.

Parameters:
- CNT_W, 16, width of completed-block counter.
- TIMEOUT_CYCLES, 64, engine-response watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- key_valid  in  1  key-load request
- key_sel  in  1  0 = key1, 1 = key2
- key_data  in  64  key value
- key_ready  out  1  key request accepted this cycle when high with key_valid
- in_valid  in  1  block request
- in_decrypt  in  1  0 = encrypt, 1 = decrypt
- in_data  in  64  plaintext/ciphertext block
- in_ready  out  1  block accepted when high with in_valid
- out_valid  out  1  result available
- out_data  out  64  result, passed unmodified from des_data_out
- out_ready  in  1  consumer accepts result
- des_enable  out  1  one-cycle command strobe to engine
- des_mode  out  3  command code
- des_data_in  out  64  key or block for the engine
- des_data_ready  in  1  engine result strobe
- des_data_out  in  64  engine result, valid when des_data_ready
- keys_loaded  out  2  bit0 = key1 written, bit1 = key2 written
- blk_count  out  CNT_W  completed blocks, wraps to 0 past all-ones
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values: all outputs 0; FSM goes to IDLE.
- Reset asserted mid-operation aborts everything: any buffered result is dropped and keys_loaded is cleared.
- Command codes: KEY1 = 3'b010, KEY2 = 3'b011, ENC = 3'b001, DEC = 3'b000. des_mode is KEY1 in IDLE.
- FSM states: IDLE, KEY_CMD, BLK_CMD, WAIT_RES, HOLD_OUT.
- IDLE:
  - key_ready = 1.
  - in_ready = (keys_loaded == 2'b11) && !out_valid.
  - If key_valid and in_valid are both high, the key wins and in_ready is forced 0 that cycle.
  - Key handshake: register key_sel/key_data, then go to KEY_CMD.
  - Block handshake: register in_decrypt/in_data, then go to BLK_CMD.
- KEY_CMD (one cycle):
  - des_enable = 1, des_mode = KEY1 or KEY2, des_data_in = key.
  - Set the matching keys_loaded bit; return to IDLE.
  - Key latency: accepted cycle N, strobe at N+1, key_ready high again at N+2.
- BLK_CMD (one cycle):
  - des_enable = 1, des_mode = ENC or DEC, des_data_in = block.
  - Go to WAIT_RES.
- WAIT_RES:
  - des_enable = 0, des_data_in holds its value.
  - On des_data_ready: capture des_data_out into out_data, set out_valid, increment blk_count.
  - Then go to HOLD_OUT if out_ready is low, otherwise to IDLE.
  - A des_data_ready seen in any other state is ignored.
- Output handshake:
  - out_valid stays high until out_valid && out_ready.
  - out_data is stable while out_valid is high.
  - HOLD_OUT returns to IDLE on that handshake.
  - No new block is accepted while out_valid is high, so there is at most one block in flight.
- des_enable is never high for two consecutive cycles.
- Block requests made before both keys are loaded stall (in_ready = 0); they are never dropped.
- Reloading a key while idle is legal; it updates that key for subsequent blocks.
- blk_count wraps from all-ones to 0.

Optional Feature:
- Macro: TDES_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in WAIT_RES.
  - If it reaches TIMEOUT_CYCLES with no des_data_ready: out_valid is set, out_data = 64'h0, blk_count is not incremented, and the sticky output err_timeout (1 bit) is set. The FSM proceeds as for a normal result.
  - err_timeout is cleared only by reset.
- Without the macro: there is no err_timeout port, and WAIT_RES waits indefinitely.

Decomposition:
- Package tdes_pkg holds:
  - the command-code constants (KEY1, KEY2, ENC, DEC);
  - the FSM state enum;
  - the 64-bit block typedef.
- One natural sub-module: tdes_out_buf (one-entry result register with valid/ready).
- The FSM and counters stay in the top module.

Test Plan:
- Key loading: reset, then key_valid with key_sel = 0, key_data = 64'h0123456789ABCDEF, then key_sel = 1 with 64'hFEDCBA9876543210 -> des_enable pulses with des_mode 010 then 011, des_data_in equals each key, keys_loaded = 2'b11.
- Stall before keys: in_valid with only key1 loaded -> in_ready stays 0 and no des_enable. Load key2 -> block accepted next idle cycle; des_mode = 001 for in_decrypt = 0.
- Round trip: engine model returns 64'hDEADBEEFCAFEF00D five cycles after the strobe, out_ready = 1 -> out_valid for one cycle with that data, blk_count = 1.
- Backpressure: out_ready held 0 for 10 cycles with in_valid high -> out_data stable, in_ready = 0, no second des_enable. On release, the next block issues with des_mode = 000 for decrypt.
- Reset mid-operation and wrap: n_rst asserted in WAIT_RES -> all outputs 0 immediately. With CNT_W = 2, after 4 blocks -> blk_count = 0.
- Timeout (TIMEOUT_CYCLES = 8, macro on): engine never responds -> out_valid after 8 wait cycles with out_data = 0, err_timeout = 1, blk_count unchanged.
